sm4_round_sequencer: RTL and testbench
======================================

// Module: sm4_round_sequencer
// PURPOSE
//  Iterative SM4 block-cipher controller: sequences one shared round datapath over 32 rounds per 128-bit block.
//  Holds 32 preloaded round keys; walks them forward (encrypt) or reverse (decrypt); applies final word reversal.
//  Sits between the upstream block source (valid/ready) and downstream sink (valid/ready); one block in flight.
// PARAMETERS
//  ROUNDS  32  rounds per block; must be even; sizes key bank and round counter ($clog2(ROUNDS) bits)
// PORTS
//  clk          in   1    single clock, rising edge
//  rst          in   1    asynchronous, active-high reset
//  key_wr_en    in   1    write round_key[key_wr_addr] <= key_wr_data; honoured only when in IDLE
//  key_wr_addr  in   5    round-key index 0..ROUNDS-1
//  key_wr_data  in   32   round key rk_i
//  in_valid     in   1    input block offered
//  in_ready     out  1    high only in IDLE
//  in_data      in   128  {X0,X1,X2,X3}, X0 in [127:96]
//  in_decrypt   in   1    sampled with block: 0 = encrypt (rk0..rk31), 1 = decrypt (rk31..rk0)
//  out_valid    out  1    result held until out_ready
//  out_ready    in   1    sink accepts
//  out_data     out  128  {X35,X34,X33,X32}
//  busy         out  1    high in RUN or DONE
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=0 during reset then 1, out_valid=0, busy=0, out_data=0, counter=0, state reg=0.
//   Key bank not reset; bench loads keys before use.
//  FSM IDLE -> RUN on in_valid&in_ready: latch in_data into state reg, latch in_decrypt, counter=0.
//  RUN: each cycle state reg <= {X1,X2,X3,X0^T(X1^X2^X3^rk)} with rk = key[cnt] (enc) or key[ROUNDS-1-cnt] (dec).
//   counter increments per round; after the round with cnt=ROUNDS-1 -> DONE.
//  DONE: out_valid=1, out_data = word-reversed state reg; on out_ready -> IDLE next cycle.
//  Latency: accept at edge N; out_valid high from edge N+ROUNDS; out_data stable while out_valid&!out_ready.
//  Throughput: one block per ROUNDS+2 cycles minimum (in_ready low in DONE; one-cycle bubble).
//  Key writes: ignored (no effect) while busy; simultaneous key_wr_en and accept in IDLE: write lands first,
//   visible from the first round.
//  in_valid while busy: ignored, in_ready=0; upstream holds.
//  Counter wraps only via FSM reset to 0 on accept; no modular wrap inside a block.
//  Reset mid-RUN/DONE: block discarded, IDLE, out_valid=0 immediately (async).
//  Encrypt and decrypt use identical datapath; only key index order differs.
// CONFIGURATION
//  SM4_SEQ_UNROLL2_EN defined: two round datapaths chained, two rounds per cycle with key pair
//   (cnt, cnt+1) in enc order or (ROUNDS-1-cnt, ROUNDS-2-cnt) in dec order; counter steps by 2;
//   RUN lasts ROUNDS/2 cycles; latency N+ROUNDS/2.
//  Undefined: single round datapath, one round per cycle, latency N+ROUNDS. Interface identical either way.
// STRUCTURE
//  sm4_pkg: SM4_ROUNDS=32, SM4_KEY_AW=5, word/block typedefs (32/128 bit), state enum {IDLE,RUN,DONE}.
//  Sub-module sm4_rk_bank: ROUNDSx32 key register file, one write port, one (two under UNROLL2) read ports,
//   combinational read.
//  Round datapath: instance(s) of the existing one_round_for_encdec round block; no S-box logic here.
// TESTING
//  Std vector: keys from key 0123456789abcdeffedcba9876543210 (rk0=f12186f9, rk31=9124a012),
//   enc in_data=0123456789abcdeffedcba9876543210 -> out_data=681edf34d206965e86b3e94f536e4246 at N+32.
//  Decrypt same keys, in_data=681edf34d206965e86b3e94f536e4246, in_decrypt=1 -> 0123456789abcdeffedcba9876543210.
//  Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0; out_ready=1 ->
//   IDLE, next block accepted one cycle later.
//  Key write during RUN to addr 0 with 00000000 -> ignored; second encryption of std vector still
//   gives 681edf34....
//  Assert rst at round 15 -> out_valid=0, busy=0 at once; new block after release encrypts correctly.
//  Build with SM4_SEQ_UNROLL2_EN: std vector same result, out_valid at N+16.

Source files
------------

// File: rtl/sm4_pkg.sv
// Shared SM4 sequencer types: round count, key address width, word/block types and FSM states.
package sm4_pkg;

    localparam int unsigned SM4_ROUNDS = 32;
    localparam int unsigned SM4_KEY_AW = 5;

    typedef logic [31:0]  sm4_word_t;
    typedef logic [127:0] sm4_block_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } sm4_state_e;

    // {X32,X33,X34,X35} -> {X35,X34,X33,X32}
    function automatic sm4_block_t sm4_word_rev(input sm4_block_t b);
        return {b[31:0], b[63:32], b[95:64], b[127:96]};
    endfunction

endpackage

// File: rtl/one_round_for_encdec.sv
// One SM4 round: {X0,X1,X2,X3} -> {X1,X2,X3,X0^T(X1^X2^X3^rk)}; identical for encrypt and decrypt.
module one_round_for_encdec
    import sm4_pkg::*;
(
    input  sm4_block_t x_i,
    input  sm4_word_t  rk_i,
    output sm4_block_t x_o
);

    localparam logic [2047:0] SboxTbl = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    // Entry 0 sits in the top byte, so entry b starts at bit 8*(255-b) = {~b, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        base = {~b, 3'b000};
        return SboxTbl[base +: 8];
    endfunction

    function automatic sm4_word_t rol(input sm4_word_t a, input int unsigned n);
        return (a << n) | (a >> (32 - n));
    endfunction

    sm4_word_t x0, x1, x2, x3;
    sm4_word_t t_in, tau_out, l_out;

    always_comb begin
        x0   = x_i[127:96];
        x1   = x_i[95:64];
        x2   = x_i[63:32];
        x3   = x_i[31:0];
        t_in = x1 ^ x2 ^ x3 ^ rk_i;
        tau_out = {sbox(t_in[31:24]), sbox(t_in[23:16]), sbox(t_in[15:8]), sbox(t_in[7:0])};
        l_out = tau_out ^ rol(tau_out, 2) ^ rol(tau_out, 10) ^ rol(tau_out, 18) ^ rol(tau_out, 24);
        x_o  = {x1, x2, x3, x0 ^ l_out};
    end

endmodule

// File: rtl/sm4_rk_bank.sv
// Round-key register file: one write port, combinational read (second read port with SM4_SEQ_UNROLL2_EN).
module sm4_rk_bank
    import sm4_pkg::*;
#(
    parameter int unsigned Rounds = SM4_ROUNDS,
    localparam int unsigned Aw    = $clog2(Rounds)
) (
    input  logic            clk_i,
    input  logic            wr_en_i,
    input  logic [Aw-1:0]   wr_addr_i,
    input  sm4_word_t       wr_data_i,
`ifdef SM4_SEQ_UNROLL2_EN
    input  logic [Aw-1:0]   rd_addr1_i,
    output sm4_word_t       rd_data1_o,
`endif
    input  logic [Aw-1:0]   rd_addr0_i,
    output sm4_word_t       rd_data0_o
);

    // Keys are always loaded before use, so the bank carries no reset.
    sm4_word_t mem_q [Rounds];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data0_o = mem_q[rd_addr0_i];
`ifdef SM4_SEQ_UNROLL2_EN
    assign rd_data1_o = mem_q[rd_addr1_i];
`endif

endmodule

// File: rtl/sm4_round_sequencer.sv
// Iterative SM4 controller: one block in flight, 32 rounds over a shared round datapath.
// Define SM4_SEQ_UNROLL2_EN to chain two round datapaths and run two rounds per cycle.
module sm4_round_sequencer
    import sm4_pkg::*;
#(
    parameter int unsigned ROUNDS = SM4_ROUNDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_wr_en,
    input  logic [SM4_KEY_AW-1:0] key_wr_addr,
    input  sm4_word_t             key_wr_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  sm4_block_t            in_data,
    input  logic                  in_decrypt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output sm4_block_t            out_data,
    output logic                  busy
);

    localparam int unsigned CntW = $clog2(ROUNDS);
    localparam logic [CntW-1:0] MaxIdx = CntW'(ROUNDS - 1);
`ifdef SM4_SEQ_UNROLL2_EN
    localparam logic [CntW-1:0] Step    = CntW'(2);
    localparam logic [CntW-1:0] LastCnt = CntW'(ROUNDS - 2);
`else
    localparam logic [CntW-1:0] Step    = CntW'(1);
    localparam logic [CntW-1:0] LastCnt = CntW'(ROUNDS - 1);
`endif

    sm4_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    sm4_block_t      blk_q;
    logic            dec_q;

    logic [CntW-1:0] rk_idx0;
    sm4_word_t       rk0;
    sm4_block_t      rnd0_out;
    sm4_block_t      blk_d;

    assign rk_idx0 = dec_q ? (MaxIdx - cnt_q) : cnt_q;

`ifdef SM4_SEQ_UNROLL2_EN
    logic [CntW-1:0] rk_idx1;
    sm4_word_t       rk1;
    sm4_block_t      rnd1_out;

    assign rk_idx1 = dec_q ? (MaxIdx - cnt_q - CntW'(1)) : (cnt_q + CntW'(1));
`endif

    // Writes only land in IDLE; a write coinciding with accept is visible to the first round.
    sm4_rk_bank #(
        .Rounds (ROUNDS)
    ) u_rk_bank (
        .clk_i      (clk),
        .wr_en_i    (key_wr_en && (state_q == StIdle)),
        .wr_addr_i  (key_wr_addr[CntW-1:0]),
        .wr_data_i  (key_wr_data),
`ifdef SM4_SEQ_UNROLL2_EN
        .rd_addr1_i (rk_idx1),
        .rd_data1_o (rk1),
`endif
        .rd_addr0_i (rk_idx0),
        .rd_data0_o (rk0)
    );

    one_round_for_encdec u_round0 (
        .x_i  (blk_q),
        .rk_i (rk0),
        .x_o  (rnd0_out)
    );

`ifdef SM4_SEQ_UNROLL2_EN
    one_round_for_encdec u_round1 (
        .x_i  (rnd0_out),
        .rk_i (rk1),
        .x_o  (rnd1_out)
    );

    assign blk_d = rnd1_out;
`else
    assign blk_d = rnd0_out;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            blk_q   <= '0;
            dec_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        blk_q   <= in_data;
                        dec_q   <= in_decrypt;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    blk_q <= blk_d;
                    if (cnt_q == LastCnt) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + Step;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_data  = sm4_word_rev(blk_q);

endmodule

// File: tb/tb_sm4_round_sequencer.sv
// Scoreboard bench for sm4_round_sequencer: std vectors, backpressure, key-write rules, reset, random.
module tb_sm4_round_sequencer;

    localparam logic [127:0] Pt = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] Ct = 128'h681edf34d206965e86b3e94f536e4246;
`ifdef SM4_SEQ_UNROLL2_EN
    localparam int Lat = 16;
`else
    localparam int Lat = 32;
`endif

    localparam logic [2047:0] SboxTbl = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_wr_en = 1'b0;
    logic [4:0]   key_wr_addr = '0;
    logic [31:0]  key_wr_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         in_decrypt = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [127:0] sb_q [$];
    logic [31:0]  rk_m [32];

    sm4_round_sequencer u_dut (
        .clk         (clk),
        .rst         (rst),
        .key_wr_en   (key_wr_en),
        .key_wr_addr (key_wr_addr),
        .key_wr_data (key_wr_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_decrypt  (in_decrypt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sbox(input logic [7:0] b);
        int idx;
        idx = 255 - int'(b);
        return SboxTbl[idx*8 +: 8];
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] a, input int n);
        return (a << n) | (a >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] a);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = sbox(a[8*j +: 8]);
        return r;
    endfunction

    function automatic logic [31:0] t_enc(input logic [31:0] a);
        logic [31:0] b;
        b = tau(a);
        return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    endfunction

    function automatic logic [31:0] t_key(input logic [31:0] a);
        logic [31:0] b;
        b = tau(a);
        return b ^ rol(b, 13) ^ rol(b, 23);
    endfunction

    function automatic logic [127:0] sm4_ref(input logic [127:0] blk, input logic dec);
        logic [31:0] x0, x1, x2, x3, t, k;
        {x0, x1, x2, x3} = blk;
        for (int i = 0; i < 32; i++) begin
            k  = dec ? rk_m[31-i] : rk_m[i];
            t  = x0 ^ t_enc(x1 ^ x2 ^ x3 ^ k);
            x0 = x1;
            x1 = x2;
            x2 = x3;
            x3 = t;
        end
        return {x3, x2, x1, x0};
    endfunction

    task automatic expand_keys(input logic [127:0] mk);
        logic [31:0] fk [4];
        logic [31:0] k [36];
        logic [31:0] ck;
        fk = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
        for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ fk[i];
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
            k[i+4]  = k[i] ^ t_key(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            rk_m[i] = k[i+4];
        end
    endtask

    task automatic load_keys();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            key_wr_en   = 1'b1;
            key_wr_addr = 5'(i);
            key_wr_data = rk_m[i];
        end
        @(negedge clk);
        key_wr_en = 1'b0;
    endtask

    // kw_lat: 0 = key-0 write alongside accept, >0 = write that many cycles into RUN, <0 = none.
    task automatic run_block(input logic [127:0] din, input logic dec, input logic [127:0] exp,
                             input int hold, input int kw_lat, input logic [31:0] kw_data);
        int waited;
        int lat;
        logic [127:0] e;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check_eq("in_ready_idle", 128'(in_ready), 128'(1));
        in_valid    = 1'b1;
        in_data     = din;
        in_decrypt  = dec;
        key_wr_en   = (kw_lat == 0);
        key_wr_addr = '0;
        key_wr_data = kw_data;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        key_wr_en = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            key_wr_en = (kw_lat > 0) && (lat == kw_lat);
            @(posedge clk);
            #1;
            key_wr_en = 1'b0;
            lat++;
        end
        check_eq("latency", 128'(lat), 128'(Lat));
        check_eq("busy_done", 128'(busy), 128'(1));
        check_eq("in_ready_done", 128'(in_ready), 128'(0));
        if (sb_q.size() == 0) begin
            check_eq("scoreboard_empty", 128'(0), 128'(1));
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
        check_eq("out_data", out_data, e);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check_eq("hold_out_data", out_data, e);
            check_eq("hold_out_valid", 128'(out_valid), 128'(1));
            check_eq("hold_in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("post_out_valid", 128'(out_valid), 128'(0));
        check_eq("post_in_ready", 128'(in_ready), 128'(1));
        check_eq("post_busy", 128'(busy), 128'(0));
    endtask

    initial begin
        logic [31:0]  rk0_save;
        logic [127:0] rnd_pt;
        logic [127:0] rnd_ct;

        #1;
        check_eq("rst_in_ready", 128'(in_ready), 128'(0));
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_out_data", out_data, 128'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("release_in_ready", 128'(in_ready), 128'(1));

        expand_keys(Pt);
        load_keys();

        run_block(Pt, 1'b0, Ct, 0, -1, 32'h0);
        run_block(Ct, 1'b1, Pt, 0, -1, 32'h0);
        run_block(Pt, 1'b0, Ct, 10, -1, 32'h0);

        // Key-0 write while running must be dropped.
        run_block(Pt, 1'b0, Ct, 0, 5, 32'h0);
        run_block(Pt, 1'b0, Ct, 0, -1, 32'h0);

        // Write alongside accept lands before round 0.
        rk0_save = rk_m[0];
        rk_m[0]  = 32'h0;
        run_block(Pt, 1'b0, sm4_ref(Pt, 1'b0), 0, 0, 32'h0);
        rk_m[0]  = rk0_save;
        run_block(Pt, 1'b0, Ct, 0, 0, rk0_save);

        // Reset in the middle of a block.
        @(negedge clk);
        in_valid   = 1'b1;
        in_data    = Pt;
        in_decrypt = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (Lat / 2 - 1) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("midrst_out_valid", 128'(out_valid), 128'(0));
        check_eq("midrst_busy", 128'(busy), 128'(0));
        check_eq("midrst_in_ready", 128'(in_ready), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        run_block(Pt, 1'b0, Ct, 0, -1, 32'h0);

        for (int r = 0; r < 3; r++) begin
            rnd_pt = {$urandom, $urandom, $urandom, $urandom};
            rnd_ct = sm4_ref(rnd_pt, 1'b0);
            run_block(rnd_pt, 1'b0, rnd_ct, r, -1, 32'h0);
            run_block(rnd_ct, 1'b1, rnd_pt, 0, -1, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
